// File: rtl/rand_num_compare_pkg.sv
// Shared types for the frame-based rank/compare block: FSM states and result modes.
package rand_num_compare_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_SUM   = 1'b0,
    MODE_RANGE = 1'b1
  } mode_t;

endpackage

// File: rtl/rand_num_compare_seq_rank2_tracker.sv
// Tracks the two largest and two smallest samples seen since the last clear.
// The *_next outputs already include this cycle's update so callers can register results on the same edge.
module rank2_tracker #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             update,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] max1_next,
  output logic [WIDTH-1:0] max2_next,
  output logic [WIDTH-1:0] min1_next,
  output logic [WIDTH-1:0] min2_next
);

  logic [WIDTH-1:0] max1_q, max2_q, min1_q, min2_q;
  logic [1:0]       fill_q, fill_d;
  logic             second;

  assign second = (fill_q == 2'd1);

  // After one sample the second slots hold a copy, so the second sample must always displace it.
  always_comb begin
    max1_next = max1_q;
    max2_next = max2_q;
    min1_next = min1_q;
    min2_next = min2_q;
    fill_d    = fill_q;
    if (clear) begin
      max1_next = '0;
      max2_next = '0;
      min1_next = '0;
      min2_next = '0;
      fill_d    = 2'd0;
    end else if (update) begin
      if (fill_q == 2'd0) begin
        max1_next = sample;
        max2_next = sample;
        min1_next = sample;
        min2_next = sample;
        fill_d    = 2'd1;
      end else begin
        fill_d = 2'd2;
        if (sample >= max1_q) begin
          max2_next = max1_q;
          max1_next = sample;
        end else if (second || sample > max2_q) begin
          max2_next = sample;
        end
        if (sample <= min1_q) begin
          min2_next = min1_q;
          min1_next = sample;
        end else if (second || sample < min2_q) begin
          min2_next = sample;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max1_q <= '0;
      max2_q <= '0;
      min1_q <= '0;
      min2_q <= '0;
      fill_q <= 2'd0;
    end else begin
      max1_q <= max1_next;
      max2_q <= max2_next;
      min1_q <= min1_next;
      min2_q <= min2_next;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/rand_num_compare_seq.sv
// Collects FRAME_LEN samples per frame and reports either top-2/bottom-2 sums or max-min range and max.
// Results are registered on the last accept and held until the consumer handshakes.
module rand_num_compare_seq
  import rand_num_compare_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_number1,
  output logic [WIDTH:0]   out_number2,
  output logic             busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  state_t           state;
  mode_t            mode_q;
  logic [CW-1:0]    cnt;
  logic             accept, clear;
  logic [WIDTH-1:0] max1_n, max2_n, min1_n, min2_n;
  logic [WIDTH:0]   res1, res2;

  assign in_ready = (state != OUTPUT);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign clear    = (state == OUTPUT) && out_ready;

  rank2_tracker #(.WIDTH(WIDTH)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .update    (accept),
    .sample    (in_number),
    .max1_next (max1_n),
    .max2_next (max2_n),
    .min1_next (min1_n),
    .min2_next (min2_n)
  );

  // Results use the tracker's post-update view so the final sample is included.
  always_comb begin
    res1 = '0;
    res2 = '0;
    if (mode_q == MODE_SUM) begin
      res1 = {1'b0, max1_n} + {1'b0, max2_n};
      res2 = {1'b0, min1_n} + {1'b0, min2_n};
    end else begin
      res1 = {1'b0, max1_n - min1_n};
      res2 = {1'b0, max1_n};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_SUM;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_number1 <= '0;
      out_number2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q <= mode ? MODE_RANGE : MODE_SUM;
            cnt    <= CW'(1);
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (cnt == CW'(FRAME_LEN - 1)) begin
              cnt         <= CW'(FRAME_LEN);
              state       <= OUTPUT;
              out_valid   <= 1'b1;
              out_number1 <= res1;
              out_number2 <= res2;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            cnt       <= '0;
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          cnt       <= '0;
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rand_num_compare_seq.md
RAND_NUM_COMPARE_SEQ -- requirements
Module: rand_num_compare_seq

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each input sample; SHALL be at least 2.
REQ-002 Parameter FRAME_LEN, default 4: samples per frame; SHALL be at least 2.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_number is valid this cycle.
REQ-006 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-007 Port in_number, input, WIDTH: unsigned sample.
REQ-008 Port mode, input, 1: 0 = SUM mode, 1 = RANGE mode; sampled with the first sample of a frame.
REQ-009 Port out_valid, output, 1: results are valid.
REQ-010 Port out_ready, input, 1: consumer takes the results.
REQ-011 Port out_number1, output, WIDTH+1: first result.
REQ-012 Port out_number2, output, WIDTH+1: second result.
REQ-013 Port busy, output, 1: high while a frame is collecting or results are pending.

Function
REQ-014 A sample SHALL be accepted only in a cycle where in_valid and in_ready are both 1; other cycles SHALL leave state unchanged.
REQ-015 FSM states SHALL be IDLE, COLLECT and OUTPUT.
- IDLE -> COLLECT on the first accept.
- COLLECT -> OUTPUT on the FRAME_LEN-th accept.
- OUTPUT -> IDLE when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE and COLLECT and 0 in OUTPUT; busy SHALL be 1 in COLLECT and OUTPUT.
REQ-017 The block SHALL track the two largest and two smallest accepted samples; equal values SHALL occupy separate slots.
REQ-018 The sample counter SHALL be $clog2(FRAME_LEN+1) bits wide, SHALL clear on entry to IDLE, and SHALL never exceed FRAME_LEN.
REQ-019 Mode SHALL be latched on the IDLE accept; mode changes during COLLECT or OUTPUT SHALL have no effect.
REQ-020 In SUM mode: out_number1 = max1+max2 and out_number2 = min1+min2, computed at WIDTH+1 bits with no overflow loss.
REQ-021 In RANGE mode: out_number1 = max1-min1 and out_number2 = max1, both zero-extended to WIDTH+1 bits.
REQ-022 Latency: out_valid SHALL rise in the cycle after the last accept, with registered results.
REQ-023 While out_valid=1 and out_ready=0, out_valid, out_number1 and out_number2 SHALL hold stable.
REQ-024 After the output handshake, in_ready SHALL return to 1 in the next cycle.
REQ-025 out_number1 and out_number2 SHALL retain their last values in IDLE; out_valid SHALL be 0 outside OUTPUT.
REQ-026 Back-to-back frames SHALL be supported with one bubble cycle (the OUTPUT cycle) between frames.

Reset
REQ-027 rst SHALL force IDLE and clear the counter and all trackers, and SHALL drive out_valid=0, busy=0, in_ready=1, out_number1=0 and out_number2=0, independent of clk.
REQ-028 Reset asserted mid-frame or during OUTPUT SHALL discard the partial frame or pending results, and the first frame after reset release SHALL be unaffected by them.

Structure
REQ-029 Package rand_num_compare_pkg SHALL hold the FSM state enum (IDLE, COLLECT, OUTPUT) and the mode enum (MODE_SUM, MODE_RANGE).
REQ-030 A single sub-module, rank2_tracker (parameter WIDTH), SHALL hold the max1/max2/min1/min2 registers.
- Inputs: clear, update, sample.
- On the first update after clear, all four slots SHALL load the sample.
- The second update SHALL order both slot pairs correctly.

Verification (WIDTH=4, FRAME_LEN=4)
REQ-031 SUM frame: 3, 12, 1, 9, mode=0 -> out_number1=21, out_number2=4, out_valid one cycle after the 4th accept.
REQ-032 RANGE frame: 3, 12, 1, 9, mode=1 -> out_number1=11, out_number2=12; a mode toggle mid-frame changes nothing.
REQ-033 Extremes and ties:
- 15, 15, 0, 0, mode=0 -> 30, 0.
- 7, 7, 7, 7, mode=0 -> 14, 14.
REQ-034 Backpressure: out_ready held 0 for 3 cycles -> out_valid and results stable, in_ready=0, extra in_valid samples ignored; on release the next frame starts cleanly.
REQ-035 Reset after 2 accepts -> all outputs 0 immediately; then frame 5, 6, 2, 8, mode=0 -> 14, 7.
REQ-036 Two back-to-back frames with in_valid held 1 -> exactly one in_ready=0 cycle between frames; both results correct.
